// File: rtl/alu_arbiter_pkg.sv
// Shared core definitions: ALU opcode encodings and the arbiter's priority type.
// Used by the arbiter, the ALU control decoder and the ALU itself.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SUM   = 4'b0010;
    localparam logic [3:0] ALU_EQUAL = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_XOR   = 4'b1000;
    localparam logic [3:0] ALU_SUB   = 4'b1010;
    localparam logic [3:0] ALU_GE    = 4'b1100;
    localparam logic [3:0] ALU_GE_U  = 4'b1101;
    localparam logic [3:0] ALU_SLT   = 4'b1110;
    localparam logic [3:0] ALU_SLT_U = 4'b1111;

    // Opcode placed on the shared ALU when nobody is granted.
    localparam logic [3:0] ALU_IDLE_OP = ALU_SUM;

    typedef enum logic {
        PRIO_0 = 1'b0,
        PRIO_1 = 1'b1
    } prio_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response holding register for a single requester.
// free is high when the slot can take a new result this cycle (empty or being drained).
module alu_rsp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] result_in,
    input  logic             zero_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             free
);

    assign free = !valid || ready;

    // A load wins over a drain so drain+refill keeps valid high with the new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= result_in;
            zero   <= zero_in;
        end else if (valid && ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared external combinational ALU.
// Each requester owns a one-entry response slot; results appear one cycle after grant.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int RR_RESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_aluop,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_aluop,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload hold steady until that transfer, and ready for a
    // request never waits on anything but slot space and arbitration.

    localparam prio_e PRIO_RESET = (RR_RESET != 0) ? PRIO_1 : PRIO_0;

    prio_e prio;
    logic  free0, free1;
    logic  elig0, elig1;
    logic  grant0, grant1;

    assign elig0 = rst_n && req0_valid && free0;
    assign elig1 = rst_n && req1_valid && free1;

    assign grant0 = elig0 && (!elig1 || (prio == PRIO_0));
    assign grant1 = elig1 && (!elig0 || (prio == PRIO_1));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_op = ALU_IDLE_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (grant0) begin
            alu_op = req0_aluop;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (grant1) begin
            alu_op = req1_aluop;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= PRIO_RESET;
        end else if (grant0) begin
            prio <= PRIO_1;
        end else if (grant1) begin
            prio <= PRIO_0;
        end
    end

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (grant0),
        .result_in (alu_result),
        .zero_in   (alu_zero),
        .ready     (rsp0_ready),
        .valid     (rsp0_valid),
        .result    (rsp0_result),
        .zero      (rsp0_zero),
        .free      (free0)
    );

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (grant1),
        .result_in (alu_result),
        .zero_in   (alu_zero),
        .ready     (rsp1_ready),
        .valid     (rsp1_valid),
        .result    (rsp1_result),
        .zero      (rsp1_zero),
        .free      (free1)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_aluop, req1_aluop;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic         rsp0_zero, rsp1_zero;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .RR_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
    );

    // external ALU model
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND:   alu_result = alu_a & alu_b;
            ALU_OR:    alu_result = alu_a | alu_b;
            ALU_SUM:   alu_result = alu_a + alu_b;
            ALU_SUB:   alu_result = alu_a - alu_b;
            ALU_XOR:   alu_result = alu_a ^ alu_b;
            ALU_SLL:   alu_result = alu_a << alu_b[4:0];
            ALU_SRL:   alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:   alu_result = $signed(alu_a) >>> alu_b[4:0];
            ALU_EQUAL: alu_result = {31'd0, alu_a == alu_b};
            ALU_SLT:   alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLT_U: alu_result = {31'd0, alu_a < alu_b};
            ALU_GE:    alu_result = {31'd0, $signed(alu_a) >= $signed(alu_b)};
            ALU_GE_U:  alu_result = {31'd0, alu_a >= alu_b};
            default:   alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req0(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = v; req0_aluop = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive_req1(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = v; req1_aluop = op; req1_a = a; req1_b = b;
    endtask

    task automatic idle_reqs();
        drive_req0(1'b0, ALU_AND, '0, '0);
        drive_req1(1'b0, ALU_AND, '0, '0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        idle_reqs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] g;
        rst_n = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        idle_reqs();

        // reset state, with a request held to show it is not accepted
        @(negedge clk);
        drive_req0(1'b1, ALU_SUM, 32'd5, 32'd7);
        #1;
        check_val("rst_req0_ready", W'(req0_ready), 0);
        check_val("rst_alu_op", W'(alu_op), W'(ALU_SUM));
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_rsp0_valid", W'(rsp0_valid), 0);
        check_val("rst_rsp1_valid", W'(rsp1_valid), 0);
        check_val("rst_rsp0_result", rsp0_result, 0);
        check_val("rst_rsp1_zero", W'(rsp1_zero), 0);
        tick();
        rst_n = 1'b1;
        idle_reqs();
        #1;
        check_val("idle_alu_op", W'(alu_op), W'(ALU_SUM));
        check_val("idle_alu_b", alu_b, 0);
        tick();

        // single request: 5 + 7
        drive_req0(1'b1, ALU_SUM, 32'd5, 32'd7);
        rsp0_ready = 1'b1;
        #1;
        check_val("single_req0_ready", W'(req0_ready), 1);
        check_val("single_req1_ready", W'(req1_ready), 0);
        check_val("single_alu_a", alu_a, 32'd5);
        check_val("single_alu_b", alu_b, 32'd7);
        tick();
        idle_reqs();
        #1;
        check_val("single_rsp0_valid", W'(rsp0_valid), 1);
        check_val("single_rsp0_result", rsp0_result, 32'd12);
        check_val("single_rsp0_zero", W'(rsp0_zero), 0);
        tick();
        #1;
        check_val("drain_rsp0_valid", W'(rsp0_valid), 0);
        check_val("drain_rsp0_result", rsp0_result, 32'd12);

        // contention: alternate 0,1,0,1... starting at the reset priority
        reset_pulse();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive_req0(1'b1, ALU_SUB, 32'd9, 32'd9);
        drive_req1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
        exp_q = {0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            #1;
            g = exp_q.pop_front();
            check_val("rr_req0_ready", W'(req0_ready), W'(g == 0));
            check_val("rr_req1_ready", W'(req1_ready), W'(g == 1));
            if (i > 0 && g == 1) begin
                check_val("rr_rsp0_valid", W'(rsp0_valid), 1);
                check_val("rr_rsp0_result", rsp0_result, 0);
                check_val("rr_rsp0_zero", W'(rsp0_zero), 1);
            end
            if (i > 0 && g == 0) begin
                check_val("rr_rsp1_valid", W'(rsp1_valid), 1);
                check_val("rr_rsp1_result", rsp1_result, 32'hFF);
                check_val("rr_rsp1_zero", W'(rsp1_zero), 0);
                check_val("rr_rsp0_cleared", W'(rsp0_valid), 0);
            end
            tick();
        end

        // backpressure on slot 0
        reset_pulse();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        drive_req0(1'b1, ALU_SUM, 32'd1, 32'd2);
        #1;
        check_val("bp_first_grant", W'(req0_ready), 1);
        tick();
        drive_req0(1'b1, ALU_SUM, 32'd10, 32'd20);
        drive_req1(1'b1, ALU_AND, 32'hC, 32'hA);
        #1;
        check_val("bp_stall_req0", W'(req0_ready), 0);
        check_val("bp_grant_req1", W'(req1_ready), 1);
        check_val("bp_hold_valid", W'(rsp0_valid), 1);
        check_val("bp_hold_result", rsp0_result, 32'd3);
        tick();
        #1;
        check_val("bp_full_skip_req0", W'(req0_ready), 0);
        check_val("bp_full_req1", W'(req1_ready), 1);
        check_val("bp_hold_result2", rsp0_result, 32'd3);
        check_val("bp_rsp1_result", rsp1_result, 32'h8);
        tick();
        rsp0_ready = 1'b1;
        drive_req1(1'b0, ALU_AND, '0, '0);
        #1;
        check_val("bp_release_req0", W'(req0_ready), 1);
        check_val("bp_release_alu_a", alu_a, 32'd10);
        tick();
        idle_reqs();
        #1;
        check_val("bp_new_valid", W'(rsp0_valid), 1);
        check_val("bp_new_result", rsp0_result, 32'd30);

        // drain and refill every cycle: SLT -1 < 0
        drive_req0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("dr_req0_ready", W'(req0_ready), 1);
            if (i > 0) begin
                check_val("dr_rsp0_valid", W'(rsp0_valid), 1);
                check_val("dr_rsp0_result", rsp0_result, 32'd1);
            end
            tick();
        end
        idle_reqs();
        #1;
        check_val("dr_last_result", rsp0_result, 32'd1);
        tick();

        // reset right after a grant
        rsp0_ready = 1'b0;
        drive_req0(1'b1, ALU_SUM, 32'd3, 32'd4);
        #1;
        check_val("mr_grant", W'(req0_ready), 1);
        tick();
        rst_n = 1'b0;
        idle_reqs();
        #1;
        check_val("mr_loaded", W'(rsp0_valid), 1);
        check_val("mr_ready_in_reset", W'(req0_ready), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_val("mr_rsp0_valid", W'(rsp0_valid), 0);
        check_val("mr_rsp1_valid", W'(rsp1_valid), 0);
        check_val("mr_rsp0_result", rsp0_result, 0);
        tick();
        #1;
        check_val("mr_no_late_rsp0", W'(rsp0_valid), 0);
        check_val("mr_no_late_rsp1", W'(rsp1_valid), 0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive_req0(1'b1, ALU_OR, 32'h1, 32'h2);
        drive_req1(1'b1, ALU_OR, 32'h4, 32'h8);
        #1;
        check_val("mr_prio_req0", W'(req0_ready), 1);
        check_val("mr_prio_req1", W'(req1_ready), 0);
        tick();
        idle_reqs();
        #1;
        check_val("mr_after_result", rsp0_result, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
